// File: rtl/i2s_rx.sv
// I2S receiver: oversamples codec SCLK/LRCLK/DOUT on the system clock and
// presents signed left/right pairs on a valid/ready interface.
module i2s_rx #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              I2S_SCLK,
   input  logic              I2S_LRCLK,
   input  logic              I2S_DOUT,
   input  logic              sample_ready,
   output logic [DATA_W-1:0] left_out,
   output logic [DATA_W-1:0] right_out,
   output logic              sample_valid,
   output logic              overrun,
   output logic              frame_err,
   output logic              locked
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FULL   = CW'(DATA_W);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

   typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_e;

   state_e state_q, state_d;

   logic sclk_s1_q, sclk_s2_q, sclk_dl_q;
   logic lr_s1_q, lr_s2_q;
   logic dout_s1_q, dout_s2_q;

   logic              lr_prev_q, lr_prev_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [DATA_W-1:0] left_hold_q, left_hold_d;
   logic              left_ok_q, left_ok_d;
   logic [TW-1:0]     to_cnt_q, to_cnt_d;
   logic [DATA_W-1:0] left_out_q, left_out_d;
   logic [DATA_W-1:0] right_out_q, right_out_d;
   logic              valid_q, valid_d;
   logic              overrun_q, overrun_d;
   logic              frame_err_q, frame_err_d;

   logic sclk_rise;
   logic lr;
   logic dout;
   logic full;
   logic publish;

   assign sclk_rise = sclk_s2_q & ~sclk_dl_q;
   assign lr        = lr_s2_q;
   assign dout      = dout_s2_q;
   assign full      = (cnt_q == FULL);

   always_comb begin
      state_d     = state_q;
      lr_prev_d   = lr_prev_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      left_hold_d = left_hold_q;
      left_ok_d   = left_ok_q;
      to_cnt_d    = to_cnt_q;
      publish     = 1'b0;
      frame_err_d = 1'b0;

      if (sclk_rise) begin
         to_cnt_d  = '0;
         lr_prev_d = lr;
         if (lr != lr_prev_q) begin
            // boundary rise carries the previous slot's LSB; drop it
            cnt_d = '0;
            unique case (state_q)
               ALIGN: begin
                  if (!lr) state_d = LEFT;
               end
               LEFT: begin
                  if (lr) begin
                     if (full) begin
                        left_hold_d = sh_q;
                        left_ok_d   = 1'b1;
                     end else begin
                        frame_err_d = 1'b1;
                        left_ok_d   = 1'b0;
                     end
                     state_d = RIGHT;
                  end
               end
               RIGHT: begin
                  if (!lr) begin
                     if (left_ok_q && full) publish = 1'b1;
                     else if (!full) frame_err_d = 1'b1;
                     state_d = LEFT;
                  end
               end
               default: state_d = ALIGN;
            endcase
         end else if (!full) begin
            sh_d  = {sh_q[DATA_W-2:0], dout};
            cnt_d = cnt_q + CW'(1);
         end
      end else if (to_cnt_q == TO_MAX) begin
         state_d   = ALIGN;
         cnt_d     = '0;
         left_ok_d = 1'b0;
      end else begin
         to_cnt_d = to_cnt_q + TW'(1);
      end
   end

   always_comb begin
      left_out_d  = left_out_q;
      right_out_d = right_out_q;
      overrun_d   = overrun_q;
      valid_d     = valid_q & ~sample_ready;
      if (publish) begin
         left_out_d  = left_hold_q;
         right_out_d = sh_q;
         valid_d     = 1'b1;
         if (valid_q && !sample_ready) overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ALIGN;
         sclk_s1_q   <= 1'b0;
         sclk_s2_q   <= 1'b0;
         sclk_dl_q   <= 1'b0;
         lr_s1_q     <= 1'b0;
         lr_s2_q     <= 1'b0;
         dout_s1_q   <= 1'b0;
         dout_s2_q   <= 1'b0;
         lr_prev_q   <= 1'b0;
         cnt_q       <= '0;
         sh_q        <= '0;
         left_hold_q <= '0;
         left_ok_q   <= 1'b0;
         to_cnt_q    <= '0;
         left_out_q  <= '0;
         right_out_q <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_s1_q   <= I2S_SCLK;
         sclk_s2_q   <= sclk_s1_q;
         sclk_dl_q   <= sclk_s2_q;
         lr_s1_q     <= I2S_LRCLK;
         lr_s2_q     <= lr_s1_q;
         dout_s1_q   <= I2S_DOUT;
         dout_s2_q   <= dout_s1_q;
         lr_prev_q   <= lr_prev_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         left_hold_q <= left_hold_d;
         left_ok_q   <= left_ok_d;
         to_cnt_q    <= to_cnt_d;
         left_out_q  <= left_out_d;
         right_out_q <= right_out_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign left_out     = left_out_q;
   assign right_out    = right_out_q;
   assign sample_valid = valid_q;
   assign overrun      = overrun_q;
   assign frame_err    = frame_err_q;
   assign locked       = (state_q != ALIGN);

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: frame table plus reset, backpressure and
// SCLK-stall sequences, with the codec modelled at SCLK = clk/16.
`timescale 1ns/1ps
module tb_i2s_rx;

   logic        clk;
   logic        reset_n;
   logic        I2S_SCLK, I2S_LRCLK, I2S_DOUT;
   logic        sample_ready;
   logic [15:0] left_out, right_out;
   logic        sample_valid, overrun, frame_err, locked;

   i2s_rx #(.DATA_W(16), .TIMEOUT(1024)) dut (
      .clk(clk), .reset_n(reset_n),
      .I2S_SCLK(I2S_SCLK), .I2S_LRCLK(I2S_LRCLK), .I2S_DOUT(I2S_DOUT),
      .sample_ready(sample_ready),
      .left_out(left_out), .right_out(right_out),
      .sample_valid(sample_valid), .overrun(overrun),
      .frame_err(frame_err), .locked(locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int pubs = 0, vcyc = 0, ferrs = 0, pub_cyc = 0;
   int rise_cyc = 0, close_cyc = 0;
   logic [15:0] pub_l = '0, pub_r = '0;
   logic v_prev = 1'b0;
   logic carry = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sample_valid && !v_prev) begin
         pubs    = pubs + 1;
         pub_l   = left_out;
         pub_r   = right_out;
         pub_cyc = cyc;
      end
      if (sample_valid) vcyc = vcyc + 1;
      if (frame_err) ferrs = ferrs + 1;
      v_prev = sample_valid;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic send_rise(input logic lr, input logic d);
      I2S_SCLK  = 1'b0;
      I2S_LRCLK = lr;
      I2S_DOUT  = d;
      repeat (8) @(negedge clk);
      I2S_SCLK = 1'b1;
      rise_cyc = cyc;
      repeat (8) @(negedge clk);
   endtask

   // slot word is MSB-aligned in w; rise 0 carries the previous slot's LSB
   task automatic send_slot(input logic lr, input logic [31:0] w,
                            input int nbits, input bit skip);
      for (int i = (skip ? 1 : 0); i < nbits; i++)
         send_rise(lr, (i == 0) ? carry : w[32-i]);
      carry = w[32-nbits];
   endtask

   task automatic do_frame(input logic [31:0] l, input int lbits,
                           input logic [31:0] r);
      send_slot(1'b0, l, lbits, 1'b1);
      send_slot(1'b1, r, 32, 1'b0);
      send_rise(1'b0, carry);
      close_cyc = rise_cyc;
   endtask

   typedef struct {
      logic [31:0] l;
      int          lbits;
      logic [31:0] r;
      int          pub;
      int          ferr;
      logic [15:0] el;
      logic [15:0] er;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int p0, f0, v0, lat;

      tbl[0] = '{32'h8001_1234, 32, 32'h7FFE_5A5A, 1, 0, 16'h8001, 16'h7FFE};
      tbl[1] = '{32'h0000_FFFF, 32, 32'hFFFF_0000, 1, 0, 16'h0000, 16'hFFFF};
      tbl[2] = '{32'hA5A5_0F0F, 32, 32'h5A5A_F0F0, 1, 0, 16'hA5A5, 16'h5A5A};
      tbl[3] = '{32'hC300_0000,  8, 32'h1234_0000, 0, 1, 16'h0000, 16'h0000};
      tbl[4] = '{32'h1357_0001, 32, 32'h2468_8000, 1, 0, 16'h1357, 16'h2468};
      tbl[5] = '{32'hFFFF_FFFF, 32, 32'h0001_0000, 1, 0, 16'hFFFF, 16'h0001};

      reset_n      = 1'b0;
      I2S_SCLK     = 1'b0;
      I2S_LRCLK    = 1'b0;
      I2S_DOUT     = 1'b0;
      sample_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_left", left_out, 0);
      chk("rst_right", right_out, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_locked", locked, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      send_slot(1'b1, 32'h0F0F_0F0F, 32, 1'b0);
      chk("pre_unlocked", locked, 0);
      send_rise(1'b0, carry);
      chk("pre_locked", locked, 1);

      foreach (tbl[i]) begin
         p0 = pubs; f0 = ferrs; v0 = vcyc;
         do_frame(tbl[i].l, tbl[i].lbits, tbl[i].r);
         chk($sformatf("v%0d_pubs", i), pubs - p0, tbl[i].pub);
         chk($sformatf("v%0d_ferr", i), ferrs - f0, tbl[i].ferr);
         if (tbl[i].pub != 0) begin
            lat = pub_cyc - close_cyc;
            chk($sformatf("v%0d_left", i), pub_l, tbl[i].el);
            chk($sformatf("v%0d_right", i), pub_r, tbl[i].er);
            chk($sformatf("v%0d_lat_le4", i), (lat >= 1 && lat <= 4), 1);
            chk($sformatf("v%0d_vcyc", i), vcyc - v0, 1);
         end
      end

      sample_ready = 1'b0;
      do_frame(32'h1111_0000, 32, 32'h2222_0000);
      chk("bp1_valid", sample_valid, 1);
      chk("bp1_overrun", overrun, 0);
      chk("bp1_left", left_out, 16'h1111);
      chk("bp1_right", right_out, 16'h2222);
      do_frame(32'h3333_0000, 32, 32'h4444_0000);
      chk("bp2_valid", sample_valid, 1);
      chk("bp2_overrun", overrun, 1);
      chk("bp2_left", left_out, 16'h3333);
      chk("bp2_right", right_out, 16'h4444);
      sample_ready = 1'b1;
      @(negedge clk);
      chk("bp_drain_valid", sample_valid, 0);
      chk("bp_drain_overrun", overrun, 1);

      sample_ready = 1'b0;
      do_frame(32'h5555_0000, 32, 32'h6666_0000);
      chk("pend_valid", sample_valid, 1);
      chk("pend_overrun", overrun, 1);
      send_slot(1'b0, 32'h7777_0000, 32, 1'b1);
      send_slot(1'b1, 32'h8888_0000, 10, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mrst_left", left_out, 0);
      chk("mrst_right", right_out, 0);
      chk("mrst_valid", sample_valid, 0);
      chk("mrst_overrun", overrun, 0);
      chk("mrst_ferr", frame_err, 0);
      chk("mrst_locked", locked, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      p0 = pubs;
      send_slot(1'b1, 32'h8888_0000, 22, 1'b1);
      chk("mrst_still_unlocked", locked, 0);
      chk("mrst_no_valid", sample_valid, 0);
      sample_ready = 1'b1;
      send_rise(1'b0, carry);
      chk("mrst_relocked", locked, 1);
      chk("mrst_no_pub", pubs - p0, 0);
      do_frame(32'hBEEF_0000, 32, 32'hCAFE_0000);
      chk("mrst_pubs", pubs - p0, 1);
      chk("mrst_pub_left", pub_l, 16'hBEEF);
      chk("mrst_pub_right", pub_r, 16'hCAFE);

      sample_ready = 1'b0;
      do_frame(32'h0F0F_0000, 32, 32'hF0F0_0000);
      chk("stall_pre_valid", sample_valid, 1);
      send_slot(1'b0, 32'h1234_0000, 10, 1'b1);
      I2S_SCLK = 1'b0;
      repeat (1000) @(negedge clk);
      chk("stall_1000_locked", locked, 1);
      repeat (100) @(negedge clk);
      chk("stall_1100_locked", locked, 0);
      chk("stall_valid", sample_valid, 1);
      chk("stall_left", left_out, 16'h0F0F);
      chk("stall_right", right_out, 16'hF0F0);
      chk("stall_overrun", overrun, 0);
      sample_ready = 1'b1;
      p0 = pubs; f0 = ferrs;
      send_slot(1'b0, 32'h1234_0000, 32, 1'b1);
      send_slot(1'b1, 32'hABCD_0000, 32, 1'b0);
      chk("resume_unlocked", locked, 0);
      send_rise(1'b0, carry);
      chk("resume_locked", locked, 1);
      chk("resume_no_pub", pubs - p0, 0);
      do_frame(32'h600D_0000, 32, 32'hF00D_0000);
      chk("resume_pubs", pubs - p0, 1);
      chk("resume_left", pub_l, 16'h600D);
      chk("resume_right", pub_r, 16'hF00D);
      chk("resume_ferr", ferrs - f0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver for the codec ADC path. It captures the serial `I2S_DOUT` stream and outputs signed left/right sample pairs on a valid/ready interface.
- The codec is bus master: `I2S_SCLK` and `I2S_LRCLK` are inputs. All logic runs on the 50 MHz system clock, which oversamples the I2S pins.
- It is the receive counterpart of the existing `I2S_DIN` shift-out path in the synth top level. It feeds audio-input and loopback features.

Parameters:
- `DATA_W`, 16: bits captured per channel; MSB-first; remaining slot bits discarded.
- `TIMEOUT`, 1024: clk cycles without an `I2S_SCLK` rising edge before lock is dropped.

Ports:
- `clk`  in  1: system clock (`MAX10_CLK1_50`).
- `reset_n`  in  1: synchronous, active-low reset.
- `I2S_SCLK`  in  1: codec bit clock; asynchronous to `clk`.
- `I2S_LRCLK`  in  1: codec word select; 0 = left, 1 = right; asynchronous.
- `I2S_DOUT`  in  1: codec serial ADC data; asynchronous.
- `sample_ready`  in  1: consumer accepts the pair when high together with `sample_valid`.
- `left_out`  out  `DATA_W`: left sample, two's complement.
- `right_out`  out  `DATA_W`: right sample, two's complement.
- `sample_valid`  out  1: pair available; held until accepted.
- `overrun`  out  1: sticky; a pair was overwritten before it was accepted.
- `frame_err`  out  1: one-cycle pulse; a slot ended with fewer than `DATA_W` bits.
- `locked`  out  1: receiver is aligned to frames.

Behaviour:
- Reset (`reset_n`=0 at a `clk` edge):
  - All outputs go to 0.
  - State goes to `ALIGN`.
  - Synchronizers, bit counter, shift register and timeout counter clear.
  - Reset mid-frame discards the partial frame; a fresh 1->0 boundary is required before capture resumes.
- Input conditioning:
  - `I2S_SCLK`, `I2S_LRCLK` and `I2S_DOUT` each pass through a 2-flop synchronizer.
  - `SCLK` also gets a third delay flop.
  - `sclk_rise` = `sync_sclk & ~sclk_d`.
  - Requirement: `SCLK` high and low phases are each ≥ 2 clk periods.
- On each `sclk_rise`, sample the synchronized `lr` and `dout`. `lr_prev` holds `lr` from the previous rise.
  - Boundary rise: `lr != lr_prev`. The bit on that rise is the previous slot's LSB and is discarded. The bit counter clears to 0.
  - Data rise: when count < `DATA_W`, shift `dout` into the shift register at the LSB end and increment the count. The count saturates at `DATA_W`; further bits are ignored.
- State machine:
  - `ALIGN`: `locked`=0. On a boundary rise with `lr`=0, go to `LEFT`. All other rises are ignored.
  - `LEFT`: on a boundary rise with `lr`=1:
    - If count == `DATA_W`: latch the shift register into `left_hold` and set `left_ok`=1.
    - Else: pulse `frame_err` and set `left_ok`=0.
    - Go to `RIGHT`.
  - `RIGHT`: on a boundary rise with `lr`=0:
    - If `left_ok` and count == `DATA_W`: publish.
    - Else if count < `DATA_W`: pulse `frame_err`.
    - Go to `LEFT`.
  - `locked`=1 in `LEFT` and `RIGHT`.
- Publish:
  - On the clk edge ending the cycle where the publishing `sclk_rise` is high: `left_out` <= `left_hold`, `right_out` <= shift register, `sample_valid` <= 1.
  - Latency from the `I2S_SCLK` pin rising edge to `sample_valid`: ≤ 4 clk cycles.
- Handshake:
  - `sample_valid` & `sample_ready` completes a transfer; `sample_valid` drops next cycle unless a publish occurs in the same cycle.
  - Publish and transfer in the same cycle: new pair loaded, `sample_valid` stays 1, no overrun.
  - Publish while `sample_valid`=1 and `sample_ready`=0: new pair overwrites the old one and `overrun` <= 1. `overrun` clears only on reset.
  - `left_out`/`right_out` are stable while `sample_valid`=1 and no publish occurs.
- Timeout:
  - The counter clears on every `sclk_rise` and otherwise increments, saturating.
  - Reaching `TIMEOUT`: go to `ALIGN`, `locked`=0, partial frame discarded, `left_ok`=0.
  - `sample_valid`, the outputs and `overrun` are unaffected.
- `frame_err` never coincides with publish. `ALIGN` never raises `frame_err`.

Test Plan:
- **Normal frame.** `SCLK` = clk/16, 32-bit slots; left word 0x8001, right word 0x7FFE; `sample_ready`=1.
  -> After the right slot's closing 1->0 boundary: `left_out`=0x8001, `right_out`=0x7FFE, `sample_valid`=1 for 1 cycle, within 4 clk of the pin edge. Low 16 bits of each slot are ignored.
- **Reset released mid-right-slot.** -> `locked`=0 and no `sample_valid` until the next 1->0 boundary.
  - `locked`=1 after that boundary.
  - The first pair is published one full frame later.
- **Short left slot.** Left slot of 8 bits, then normal frames. -> `frame_err` pulses 1 cycle at the 0->1 boundary; that frame is not published; the next frame publishes correctly.
- **Backpressure.** `sample_ready`=0 across two frames (0x1111/0x2222, then 0x3333/0x4444).
  - `overrun`=1 and outputs hold 0x3333/0x4444.
  - Then `sample_ready`=1: `sample_valid`=0 next cycle, `overrun` stays 1.
- **SCLK stall.** Hold `SCLK` low for 1100 clk. -> `locked`=0 at cycle 1024, `sample_valid` unchanged. On resume, the receiver relocks on the next 1->0 boundary and publishes the following full frame.
- **Reset mid-right-slot with a pending pair.** Assert `reset_n`=0 with `sample_valid`=1 and `overrun`=1. -> All outputs 0 after the next clk edge.
